// File: rtl/alu_pkg.sv
// -----------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the sequential ALU and its combinational datapath:
// the 4-bit operation codes, the controller state type, and a helper that
// tells the controller which operations need the multi-cycle path.
// -----------------------------------------------------------------------------
package alu_pkg;

  localparam logic [3:0] OP_AND  = 4'd0;
  localparam logic [3:0] OP_OR   = 4'd1;
  localparam logic [3:0] OP_XOR  = 4'd2;
  localparam logic [3:0] OP_NOR  = 4'd3;
  localparam logic [3:0] OP_ADD  = 4'd4;
  localparam logic [3:0] OP_SUB  = 4'd5;
  localparam logic [3:0] OP_SLT  = 4'd6;
  localparam logic [3:0] OP_SLL  = 4'd7;
  localparam logic [3:0] OP_SRL  = 4'd8;
  localparam logic [3:0] OP_SRA  = 4'd9;
  localparam logic [3:0] OP_SLTU = 4'd10;
  localparam logic [3:0] OP_MULU = 4'd11;

  typedef enum logic {
    S_IDLE,
    S_MUL
  } state_t;

  // Only the multiplier iterates; every other code, reserved ones included,
  // completes in the cycle it is accepted.
  function automatic logic isMultiCycle(input logic [3:0] op);
    return (op == OP_MULU);
  endfunction

endpackage

// File: rtl/alu_comb.sv
// -----------------------------------------------------------------------------
// alu_comb
// Purely combinational single-cycle ALU datapath.
//   op  in  4      operation code (see alu_pkg)
//   A   in  WIDTH  first operand
//   B   in  WIDTH  second operand; shifts use only its low $clog2(WIDTH) bits
//   F   out WIDTH  result (0 for mulu and reserved codes)
//   OF  out 1      signed overflow for add/sub, 0 otherwise
//   CF  out 1      carry-out for add, borrow for sub, 0 otherwise
// -----------------------------------------------------------------------------
module alu_comb
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] F,
  output logic             OF,
  output logic             CF
);

  localparam int SHW = $clog2(WIDTH);
  localparam int MSB = WIDTH - 1;

  logic [WIDTH:0]   w_sum;
  logic [WIDTH:0]   w_diff;
  logic [SHW-1:0]   w_shamt;
  logic             w_ltSigned;
  logic             w_ltUnsigned;
  logic [WIDTH-1:0] w_sra;

  // The extra top bit of the unsigned difference is exactly the borrow,
  // i.e. it is set when A < B as unsigned numbers.
  assign w_sum        = {1'b0, A} + {1'b0, B};
  assign w_diff       = {1'b0, A} - {1'b0, B};
  assign w_shamt      = B[SHW-1:0];
  assign w_ltSigned   = ($signed(A) < $signed(B));
  assign w_ltUnsigned = (A < B);
  assign w_sra        = $signed(A) >>> w_shamt;

  // Result and flag selection; everything defaults to zero so that mulu
  // (handled by the sequencer) and the reserved codes fall through cleanly.
  always_comb begin
    F  = '0;
    OF = 1'b0;
    CF = 1'b0;
    case (op)
      OP_AND:  F = A & B;
      OP_OR:   F = A | B;
      OP_XOR:  F = A ^ B;
      OP_NOR:  F = ~(A | B);
      OP_ADD: begin
        F  = w_sum[WIDTH-1:0];
        CF = w_sum[WIDTH];
        OF = (A[MSB] == B[MSB]) && (w_sum[MSB] != A[MSB]);
      end
      OP_SUB: begin
        F  = w_diff[WIDTH-1:0];
        CF = w_diff[WIDTH];
        OF = (A[MSB] != B[MSB]) && (w_diff[MSB] != A[MSB]);
      end
      OP_SLT:  F = {{(WIDTH-1){1'b0}}, w_ltSigned};
      OP_SLL:  F = A << w_shamt;
      OP_SRL:  F = A >> w_shamt;
      OP_SRA:  F = w_sra;
      OP_SLTU: F = {{(WIDTH-1){1'b0}}, w_ltUnsigned};
      default: F = '0;
    endcase
  end

endmodule

// File: rtl/alu_seq.sv
// -----------------------------------------------------------------------------
// alu_seq
// Multi-cycle ALU with a start/busy/done handshake and registered results.
// Single-cycle operations complete at the edge that accepts them; mulu runs
// an iterative shift-add multiplier for WIDTH cycles.
//   clk     in  1      rising-edge clock
//   rst     in  1      asynchronous active-high reset
//   start   in  1      request, only honoured while idle
//   ALU_OP  in  4      operation code, captured with start
//   A, B    in  WIDTH  operands, captured with start
//   busy    out 1      a multiply is in flight
//   done    out 1      one-cycle pulse when F and flags were updated
//   F       out WIDTH  result, held until the next done
//   ZF      out 1      F == 0
//   OF      out 1      signed overflow (add/sub) or unsigned mul overflow
//   CF      out 1      add carry / sub borrow, 0 otherwise
// -----------------------------------------------------------------------------
module alu_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [3:0]       ALU_OP,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] F,
  output logic             ZF,
  output logic             OF,
  output logic             CF
);

  localparam int             SHW  = $clog2(WIDTH);
  localparam logic [SHW-1:0] LAST = SHW'(WIDTH - 1);

  state_t             r_state;
  state_t             w_nextState;
  logic [SHW-1:0]     r_count;
  logic [WIDTH-1:0]   r_mcand;
  logic [2*WIDTH-1:0] r_prod;
  logic [WIDTH-1:0]   r_f;
  logic               r_of;
  logic               r_cf;
  logic               r_done;

  logic [WIDTH-1:0]   w_combF;
  logic               w_combOF;
  logic               w_combCF;
  logic               w_acceptSingle;
  logic               w_acceptMul;
  logic               w_mulLast;
  logic [WIDTH:0]     w_partial;
  logic [2*WIDTH-1:0] w_prodNext;

  alu_comb #(
    .WIDTH (WIDTH)
  ) u_comb (
    .op (ALU_OP),
    .A  (A),
    .B  (B),
    .F  (w_combF),
    .OF (w_combOF),
    .CF (w_combCF)
  );

  // Shift-add step: the multiplier sits in the low half of the product
  // register and is consumed LSB first. When the current bit is set the
  // multiplicand is added into the high half; the carry of that addition
  // becomes the new top bit as the whole register shifts right by one.
  assign w_partial  = {1'b0, r_prod[2*WIDTH-1:WIDTH]} + {1'b0, r_mcand};
  assign w_prodNext = r_prod[0] ? {w_partial, r_prod[WIDTH-1:1]}
                                : {1'b0, r_prod[2*WIDTH-1:1]};

  // Controller state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next-state and handshake decode. A start is only looked at in IDLE, so
  // requests arriving during a multiply (including its final cycle) are
  // dropped rather than queued.
  always_comb begin
    w_nextState    = r_state;
    w_acceptSingle = 1'b0;
    w_acceptMul    = 1'b0;
    w_mulLast      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          if (isMultiCycle(ALU_OP)) begin
            w_acceptMul = 1'b1;
            w_nextState = S_MUL;
          end else begin
            w_acceptSingle = 1'b1;
          end
        end
      end
      S_MUL: begin
        if (r_count == LAST) begin
          w_mulLast   = 1'b1;
          w_nextState = S_IDLE;
        end
      end
      default: w_nextState = S_IDLE;
    endcase
  end

  // Datapath registers. Single-cycle results are latched straight from the
  // combinational ALU; a multiply captures its operands on acceptance so the
  // inputs are free to change, then iterates one bit per cycle and publishes
  // the final step's value directly so no extra cycle is spent.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
      r_mcand <= '0;
      r_prod  <= '0;
      r_f     <= '0;
      r_of    <= 1'b0;
      r_cf    <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (w_acceptSingle) begin
        r_f    <= w_combF;
        r_of   <= w_combOF;
        r_cf   <= w_combCF;
        r_done <= 1'b1;
      end
      if (w_acceptMul) begin
        r_mcand <= A;
        r_prod  <= {{WIDTH{1'b0}}, B};
        r_count <= '0;
      end
      if (r_state == S_MUL) begin
        r_prod  <= w_prodNext;
        r_count <= r_count + 1'b1;
      end
      if (w_mulLast) begin
        r_f     <= w_prodNext[WIDTH-1:0];
        r_of    <= |w_prodNext[2*WIDTH-1:WIDTH];
        r_cf    <= 1'b0;
        r_done  <= 1'b1;
        r_count <= '0;
      end
    end
  end

  // ZF follows the registered result, so it reads 1 out of reset as well.
  assign busy = (r_state == S_MUL);
  assign done = r_done;
  assign F    = r_f;
  assign ZF   = ~|r_f;
  assign OF   = r_of;
  assign CF   = r_cf;

endmodule

// File: tb/tb_alu_seq.sv
// -----------------------------------------------------------------------------
// tb_alu_seq
// Directed self-checking bench for alu_seq. One 32-bit and one 8-bit instance
// share the operand/opcode buses and have separate start lines; every
// expected value below is worked out by hand.
// -----------------------------------------------------------------------------
module tb_alu_seq;
  import alu_pkg::*;

  logic        clock = 1'b0;
  logic        reset;
  logic        start32;
  logic        start8;
  logic [3:0]  aluOp;
  logic [31:0] opA;
  logic [31:0] opB;

  logic        busy32, done32, zf32, of32, cf32;
  logic [31:0] f32;
  logic        busy8, done8, zf8, of8, cf8;
  logic [7:0]  f8;

  int compared   = 0;
  int mismatched = 0;

  alu_seq #(.WIDTH(32)) dut32 (
    .clk    (clock),
    .rst    (reset),
    .start  (start32),
    .ALU_OP (aluOp),
    .A      (opA),
    .B      (opB),
    .busy   (busy32),
    .done   (done32),
    .F      (f32),
    .ZF     (zf32),
    .OF     (of32),
    .CF     (cf32)
  );

  alu_seq #(.WIDTH(8)) dut8 (
    .clk    (clock),
    .rst    (reset),
    .start  (start8),
    .ALU_OP (aluOp),
    .A      (opA[7:0]),
    .B      (opB[7:0]),
    .busy   (busy8),
    .done   (done8),
    .F      (f8),
    .ZF     (zf8),
    .OF     (of8),
    .CF     (cf8)
  );

  always #5 clock = ~clock;

  // Single comparison point: counts every check and reports any difference.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    compared++;
    if (observed !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
    end
  endtask

  function automatic logic [31:0] obsF(input bit narrow);
    return narrow ? {24'h0, f8} : f32;
  endfunction

  function automatic logic [2:0] obsFlags(input bit narrow);
    return narrow ? {zf8, of8, cf8} : {zf32, of32, cf32};
  endfunction

  function automatic logic obsBusy(input bit narrow);
    return narrow ? busy8 : busy32;
  endfunction

  function automatic logic obsDone(input bit narrow);
    return narrow ? done8 : done32;
  endfunction

  task automatic driveStart(input bit narrow, input logic value);
    if (narrow) start8 = value;
    else        start32 = value;
  endtask

  // Issues one operation and follows it to completion. Inputs change on the
  // falling edge and outputs are sampled there too. After acceptance the
  // operand buses are scrambled to prove the DUT works from captured copies;
  // with hammer set, start stays high with an add request for the whole
  // multiply, which must be ignored.
  task automatic applyStimulus(input string tag, input bit narrow, input bit hammer,
                               input logic [3:0] op, input logic [31:0] a,
                               input logic [31:0] b, input logic [31:0] expF,
                               input logic expOF, input logic expCF);
    int lat;
    int earlyDone;
    int idleBusy;
    lat = (op == OP_MULU) ? (narrow ? 8 : 32) : 1;
    @(negedge clock);
    aluOp = op;
    opA   = a;
    opB   = b;
    driveStart(narrow, 1'b1);
    @(negedge clock);
    opA   = ~a;
    opB   = ~b;
    aluOp = hammer ? OP_ADD : OP_XOR;
    if (!hammer) driveStart(narrow, 1'b0);
    earlyDone = 0;
    idleBusy  = 0;
    if (lat > 1) begin
      for (int i = 0; i < lat; i++) begin
        if (obsDone(narrow))  earlyDone++;
        if (!obsBusy(narrow)) idleBusy++;
        @(negedge clock);
      end
      checkOutput({tag, " early done"}, earlyDone, 0);
      checkOutput({tag, " busy gaps"}, idleBusy, 0);
    end
    driveStart(narrow, 1'b0);
    checkOutput({tag, " done"}, obsDone(narrow), 1);
    checkOutput({tag, " busy"}, obsBusy(narrow), 0);
    checkOutput({tag, " F"}, obsF(narrow), expF);
    checkOutput({tag, " ZF/OF/CF"}, obsFlags(narrow), {expF == 32'h0, expOF, expCF});
    @(negedge clock);
    checkOutput({tag, " done pulse"}, obsDone(narrow), 0);
    checkOutput({tag, " busy after"}, obsBusy(narrow), 0);
  endtask

  // Main directed sequence.
  initial begin
    reset   = 1'b1;
    start32 = 1'b0;
    start8  = 1'b0;
    aluOp   = 4'd0;
    opA     = 32'h0;
    opB     = 32'h0;
    repeat (2) @(negedge clock);
    checkOutput("reset busy/done 32", {busy32, done32}, 2'b00);
    checkOutput("reset F 32", f32, 32'h0);
    checkOutput("reset ZF/OF/CF 32", {zf32, of32, cf32}, 3'b100);
    checkOutput("reset busy/done 8", {busy8, done8}, 2'b00);
    checkOutput("reset F/flags 8", {f8, zf8, of8, cf8}, {8'h00, 3'b100});
    reset = 1'b0;

    applyStimulus("and", 0, 0, OP_AND, 32'hF0F0F0F0, 32'h0FF00FF0, 32'h00F000F0, 0, 0);
    applyStimulus("or",  0, 0, OP_OR,  32'hF0F0F0F0, 32'h0FF00FF0, 32'hFFF0FFF0, 0, 0);
    applyStimulus("xor", 0, 0, OP_XOR, 32'hF0F0F0F0, 32'h0FF00FF0, 32'hFF00FF00, 0, 0);
    applyStimulus("nor", 0, 0, OP_NOR, 32'hF0F0F0F0, 32'h0FF00FF0, 32'h000F000F, 0, 0);
    applyStimulus("add ovf",   0, 0, OP_ADD, 32'h7FFFFFFF, 32'h1, 32'h80000000, 1, 0);
    applyStimulus("add carry", 0, 0, OP_ADD, 32'hFFFFFFFF, 32'h1, 32'h0, 0, 1);
    applyStimulus("sub ovf",    0, 0, OP_SUB, 32'h80000000, 32'h1, 32'h7FFFFFFF, 1, 0);
    applyStimulus("sub borrow", 0, 0, OP_SUB, 32'h3, 32'h5, 32'hFFFFFFFE, 0, 1);
    applyStimulus("slt",  0, 0, OP_SLT,  32'hFFFFFFFF, 32'h1, 32'h1, 0, 0);
    applyStimulus("sltu", 0, 0, OP_SLTU, 32'hFFFFFFFF, 32'h1, 32'h0, 0, 0);
    applyStimulus("sll", 0, 0, OP_SLL, 32'h00000001, 32'hFFFFFFFF, 32'h80000000, 0, 0);
    applyStimulus("srl", 0, 0, OP_SRL, 32'h80000000, 32'h00000021, 32'h40000000, 0, 0);
    applyStimulus("sra", 0, 0, OP_SRA, 32'h80000000, 32'h00000024, 32'hF8000000, 0, 0);
    applyStimulus("mulu ovf", 0, 0, OP_MULU, 32'h00010000, 32'h00010000, 32'h0, 1, 0);
    applyStimulus("mulu 1234x5678", 0, 0, OP_MULU, 32'd1234, 32'd5678, 32'd7006652, 0, 0);
    applyStimulus("mulu hammer", 0, 1, OP_MULU, 32'd300, 32'd7, 32'd2100, 0, 0);
    applyStimulus("reserved 13", 0, 0, 4'd13, 32'h12345678, 32'h9ABCDEF0, 32'h0, 0, 0);

    // Reset in the middle of a multiply, with a non-zero result held beforehand.
    applyStimulus("add 7+8", 0, 0, OP_ADD, 32'd7, 32'd8, 32'd15, 0, 0);
    @(negedge clock);
    aluOp   = OP_MULU;
    opA     = 32'd1234;
    opB     = 32'd5678;
    start32 = 1'b1;
    @(negedge clock);
    start32 = 1'b0;
    repeat (6) @(negedge clock);
    checkOutput("mid-mul busy", busy32, 1);
    reset = 1'b1;
    #1;
    checkOutput("rst mid-mul busy/done", {busy32, done32}, 2'b00);
    checkOutput("rst mid-mul F", f32, 32'h0);
    checkOutput("rst mid-mul ZF/OF/CF", {zf32, of32, cf32}, 3'b100);
    @(negedge clock);
    reset = 1'b0;
    applyStimulus("add 2+3 after rst", 0, 0, OP_ADD, 32'd2, 32'd3, 32'd5, 0, 0);

    // Narrow instance.
    applyStimulus("w8 add ovf",    1, 0, OP_ADD, 32'h7F, 32'h01, 32'h80, 1, 0);
    applyStimulus("w8 add carry",  1, 0, OP_ADD, 32'hFF, 32'h01, 32'h00, 0, 1);
    applyStimulus("w8 sub ovf",    1, 0, OP_SUB, 32'h80, 32'h01, 32'h7F, 1, 0);
    applyStimulus("w8 sub borrow", 1, 0, OP_SUB, 32'h03, 32'h05, 32'hFE, 0, 1);
    applyStimulus("w8 sra",        1, 0, OP_SRA, 32'h80, 32'h0B, 32'hF0, 0, 0);
    applyStimulus("w8 mulu ovf",   1, 0, OP_MULU, 32'd16, 32'd16, 32'h00, 1, 0);
    applyStimulus("w8 mulu 12x10", 1, 0, OP_MULU, 32'd12, 32'd10, 32'd120, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
